// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Odd parity: data plus parity bit always carries an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle tick every DIVIDER enabled cycles.
// Counter is held at zero while disabled or cleared; no backpressure.
module uart_baud_gen #(
  parameter int DIVIDER = 3125
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_W'(DIVIDER - 1));
  assign tick = enable && last;

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8O1 UART transmitter: accepted start at cycle N drives the start bit at N+1, tx_done at N+1+11*DIVIDER.
// tx_start is honoured only while tx_ready is high; requests during a frame are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 30_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done
);

  localparam int DIVIDER = CLK_FREQ / BAUD;

  generate
    if (DIVIDER < 2) begin : g_divider_check
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic                 parity, parity_n;
  logic                 tx_n, ready_n, done_n;
  logic                 tick;
  logic                 accept;

  assign accept = (state == IDLE) && tx_start;

  uart_baud_gen #(
    .DIVIDER(DIVIDER)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(state != IDLE),
    .clear (accept),
    .tick  (tick)
  );

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    parity_n  = parity;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          shift_n   = tx_data;
          parity_n  = odd_parity(tx_data);
          bit_cnt_n = 3'd0;
          state_n   = START;
        end
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_n   = shift >> 1;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (tick) state_n = STOP;
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next state so tx is a clean flop output.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = parity_n;
      default: tx_n = 1'b1;
    endcase
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= 3'd0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      parity   <= parity_n;
      tx       <= tx_n;
      tx_ready <= ready_n;
      tx_done  <= done_n;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter; the transmit-side counterpart of the team's UART receiver. Serialises one byte per request using the same frame: 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit, 1 stop bit (1). Runs at 9600 baud from a 30 MHz system clock by default. Sits between the cipher core's output byte stream and the TX pad.

Parameters:
- CLK_FREQ, 30_000_000, system clock frequency in Hz.
- BAUD, 9600, line baud rate in Hz.
- Derived localparam DIVIDER = CLK_FREQ/BAUD, integer division, so 3125 by default.
  - DIVIDER must be >= 2; elaborate-time error otherwise.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on an accepted start.
- tx_start  input  1  request to send tx_data; accepted only when tx_ready=1.
- tx  output  1  serial line; idles high.
- tx_ready  output  1  high when idle and able to accept tx_start.
- tx_done  output  1  one-cycle pulse when the stop bit has completed.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - tx=1, tx_ready=1, tx_done=0.
  - FSM=IDLE, baud counter=0, bit counter=0, shift register=0.
- Reset mid-frame: the frame is abandoned. tx=1 on the cycle after rst is sampled high. No tx_done pulse.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - tx=1, tx_ready=1.
  - On tx_start=1: latch tx_data into the shift register, latch parity = ~^tx_data, clear the baud counter, go to START.
  - tx_ready drops the cycle after acceptance.
- START: tx=0 for DIVIDER cycles, then go to DATA.
- DATA:
  - tx = shift register bit 0.
  - Each bit is held DIVIDER cycles, then the register shifts right and the bit counter increments.
  - After the 8th bit (counter 7 -> wrap), go to PARITY.
- PARITY: tx = latched parity bit for DIVIDER cycles, then go to STOP.
- STOP: tx=1 for DIVIDER cycles, then go to IDLE. tx_done=1 for exactly that one cycle, together with tx_ready=1.
- Latency and timing:
  - tx_start accepted at cycle N gives tx falling at cycle N+1.
  - Each bit lasts exactly DIVIDER cycles; frame length is 11*DIVIDER cycles.
  - tx_done is high at cycle N+1+11*DIVIDER.
- Back-to-back: a tx_start sampled in the tx_done cycle is accepted. The next start bit begins the following cycle, with no extra idle gap.
- tx_start while tx_ready=0 is ignored: not queued, no error. tx_data changes during a frame have no effect.
- Baud counter:
  - Width $clog2(DIVIDER).
  - Counts 0..DIVIDER-1, then wraps to 0 and produces a bit-end tick.
  - Held at 0 in IDLE.
- Parity is odd: the total count of ones in data+parity is odd.
  - 0x00 -> parity 1; 0x07 -> parity 0.
- Glitch-free line: tx changes only at bit boundaries.

Decomposition:
- Shared package uart_pkg holds:
  - FRAME constants: DATA_BITS=8, frame length 11.
  - State encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3 bits).
  - Odd-parity function.
  - The receiver is migrated to the same package.
- One natural sub-module: uart_baud_gen.
  - Inputs: clk, rst, enable, clear.
  - Output: a one-cycle tick every DIVIDER enabled cycles.
  - Reusable later by the receiver.

Test Plan:
- Benches use CLK_FREQ=16, BAUD=1, so DIVIDER=16.
- Reset then idle 50 cycles -> tx=1, tx_ready=1, tx_done=0 throughout.
- tx_data=0x55 with a 1-cycle tx_start -> line bits 0,1,0,1,0,1,0,1,0,1,1, each exactly 16 cycles; tx_done at start+177 cycles.
- tx_data=0x07 -> parity bit 0; tx_data=0xFF -> parity bit 1; tx_data=0x00 -> parity bit 1. A bench model checks every sampled mid-bit value.
- tx_start held high continuously with 0xA3 then 0x3C switched at tx_done -> two frames separated by zero idle cycles. The second frame carries 0x3C; extra starts during frame 1 are ignored.
- rst asserted 40 cycles into a frame -> tx=1 next cycle, tx_ready=1, no tx_done. A new 0x81 frame is sent correctly afterwards.
- Randomised 200 bytes through a bench UART decoder model -> all bytes match, parity and stop correct, tx_done count = 200.
